// File: rtl/cla_adder_pipe_pkg.sv
`default_nettype none
// ============================================================================
// vec_alu_pkg : shared types and lane helpers for the vector ALU adder
// Rev 1.0
// ============================================================================
package vec_alu_pkg;

    typedef enum logic [1:0] {
        SEW8  = 2'd0,
        SEW16 = 2'd1,
        SEW32 = 2'd2,
        SEW64 = 2'd3
    } sew_e;

    localparam int GROUP_W = 4;

    // True when lookahead group k is the least-significant group of its lane.
    // A lane wider than the datapath degenerates to a single lane at group 0.
    function automatic logic lane_first_group(input sew_e sew, input int k);
        int groups_per_lane;
        groups_per_lane = (8 << sew) / GROUP_W;
        return (k % groups_per_lane) == 0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_adder_pipe_if.sv
`default_nettype none
// ============================================================================
// cla_adder_pipe_if : operand/result handshake bundle of the pipelined adder
// Rev 1.0
// ============================================================================
interface cla_adder_pipe_if #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 4
);
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [WIDTH-1:0]     a_i;
    logic [WIDTH-1:0]     b_i;
    logic [1:0]           sew_i;
    logic                 sub_i;
    logic [TAG_W-1:0]     tag_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [WIDTH-1:0]     sum_o;
    logic [WIDTH/8-1:0]   cout_o;
    logic [TAG_W-1:0]     tag_o;

    modport master (
        output in_valid_i, a_i, b_i, sew_i, sub_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, sum_o, cout_o, tag_o
    );

    modport slave (
        input  in_valid_i, a_i, b_i, sew_i, sub_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, sum_o, cout_o, tag_o
    );
endinterface
`default_nettype wire

// File: rtl/cla_adder_pipe_group_pg.sv
`default_nettype none
// ============================================================================
// cla_group_pg : group generate/propagate cell for one lookahead group
// Rev 1.0
// ============================================================================
module cla_group_pg #(
    parameter int BITS = 4
) (
    input  wire logic [BITS-1:0] i_g,
    input  wire logic [BITS-1:0] i_p,
    output logic                 o_gg,
    output logic                 o_pp
);

    logic w_gg;
    logic w_pp;

    // Iterating LSB to MSB yields G3 | G2P3 | G1P2P3 | G0P1P2P3.
    always_comb begin
        w_gg = 1'b0;
        w_pp = 1'b1;
        for (int i = 0; i < BITS; i++) begin
            w_gg = i_g[i] | (i_p[i] & w_gg);
            w_pp = w_pp & i_p[i];
        end
    end

    assign o_gg = w_gg;
    assign o_pp = w_pp;

endmodule
`default_nettype wire

// File: rtl/cla_adder_pipe.sv
`default_nettype none
// ============================================================================
// cla_adder_pipe : two-stage SIMD-partitioned carry-lookahead add/subtract
// Rev 1.0
// ============================================================================
module cla_adder_pipe #(
    parameter int WIDTH = 64,
    parameter int GROUP = 4,
    parameter int TAG_W = 4
) (
    input  wire logic       clk_i,
    input  wire logic       rst_ni,
    cla_adder_pipe_if.slave bus
);
    import vec_alu_pkg::*;

    localparam int NG = WIDTH / GROUP;
    localparam int NB = WIDTH / 8;

    // Handshake
    logic w_adv1;
    logic w_adv2;

    // Stage-1 combinational terms
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [NG-1:0]    w_gg;
    logic [NG-1:0]    w_pp;

    // Stage-1 registers
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_g;
    logic [WIDTH-1:0] r_s1_p;
    logic [NG-1:0]    r_s1_gg;
    logic [NG-1:0]    r_s1_pp;
    sew_e             r_s1_sew;
    logic             r_s1_sub;
    logic [TAG_W-1:0] r_s1_tag;

    // Stage-2 combinational carry resolution
    logic [WIDTH-1:0] w_sum;
    logic [NB-1:0]    w_cout;
    logic [NG-1:0]    w_gco;
    logic             w_c_grp;
    logic             w_c_bit;

    // Stage-2 (output) registers
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_sum;
    logic [NB-1:0]    r_cout;
    logic [TAG_W-1:0] r_tag;

    // in_ready deliberately sees out_ready combinationally so a full pipe
    // can accept and retire on the same edge.
    assign w_adv2 = ~r_s2_valid | bus.out_ready_i;
    assign w_adv1 = ~r_s1_valid | w_adv2;

    assign w_b = bus.b_i ^ {WIDTH{bus.sub_i}};
    assign w_g = bus.a_i & w_b;
    assign w_p = bus.a_i ^ w_b;

    for (genvar k = 0; k < NG; k++) begin : g_grp
        cla_group_pg #(
            .BITS (GROUP)
        ) u_pg (
            .i_g  (w_g[k*GROUP +: GROUP]),
            .i_p  (w_p[k*GROUP +: GROUP]),
            .o_gg (w_gg[k]),
            .o_pp (w_pp[k])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_valid <= 1'b0;
            r_s1_g     <= '0;
            r_s1_p     <= '0;
            r_s1_gg    <= '0;
            r_s1_pp    <= '0;
            r_s1_sew   <= SEW8;
            r_s1_sub   <= 1'b0;
            r_s1_tag   <= '0;
        end else if (w_adv1) begin
            r_s1_valid <= bus.in_valid_i;
            if (bus.in_valid_i) begin
                r_s1_g   <= w_g;
                r_s1_p   <= w_p;
                r_s1_gg  <= w_gg;
                r_s1_pp  <= w_pp;
                r_s1_sew <= sew_e'(bus.sew_i);
                r_s1_sub <= bus.sub_i;
                r_s1_tag <= bus.tag_i;
            end
        end
    end

    // Group carries ripple across groups but restart with sub at each lane
    // start; bits inside a group ripple from that group's carry-in.
    always_comb begin
        w_sum   = '0;
        w_cout  = '0;
        w_gco   = '0;
        w_c_grp = 1'b0;
        w_c_bit = 1'b0;
        for (int k = 0; k < NG; k++) begin
            if (lane_first_group(r_s1_sew, k)) begin
                w_c_grp = r_s1_sub;
            end
            w_gco[k] = r_s1_gg[k] | (r_s1_pp[k] & w_c_grp);
            w_c_bit  = w_c_grp;
            for (int j = 0; j < GROUP; j++) begin
                w_sum[k*GROUP+j] = r_s1_p[k*GROUP+j] ^ w_c_bit;
                w_c_bit          = r_s1_g[k*GROUP+j] | (r_s1_p[k*GROUP+j] & w_c_bit);
            end
            // Upper group of a byte that closes a lane reports the lane carry.
            if ((k % 2 == 1) && ((k == NG - 1) || lane_first_group(r_s1_sew, k + 1))) begin
                w_cout[k/2] = w_gco[k];
            end
            w_c_grp = w_gco[k];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s2_valid <= 1'b0;
            r_sum      <= '0;
            r_cout     <= '0;
            r_tag      <= '0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_sum  <= w_sum;
                r_cout <= w_cout;
                r_tag  <= r_s1_tag;
            end
        end
    end

    assign bus.in_ready_o  = w_adv1;
    assign bus.out_valid_o = r_s2_valid;
    assign bus.sum_o       = r_sum;
    assign bus.cout_o      = r_cout;
    assign bus.tag_o       = r_tag;

endmodule
`default_nettype wire

// File: tb/tb_cla_adder_pipe.sv
`default_nettype none
// ============================================================================
// tb_cla_adder_pipe : directed self-checking bench for cla_adder_pipe
// Rev 1.0
// ============================================================================
module tb_cla_adder_pipe;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    cla_adder_pipe_if #(.WIDTH(64), .TAG_W(4)) bus ();

    cla_adder_pipe #(
        .WIDTH (64),
        .GROUP (4),
        .TAG_W (4)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic [1:0] sew,
                         input logic sub, input logic [3:0] tag);
        bus.a_i   = a;
        bus.b_i   = b;
        bus.sew_i = sew;
        bus.sub_i = sub;
        bus.tag_i = tag;
    endtask

    // Offers one op, waits (bounded) for its result and consumes it.
    task automatic run_single(input logic [63:0] a, input logic [63:0] b, input logic [1:0] sew,
                              input logic sub, input logic [3:0] tag,
                              output logic [63:0] sum, output logic [7:0] cout,
                              output logic [3:0] tag_out, output bit ok);
        int n;
        ok      = 1'b0;
        sum     = '0;
        cout    = '0;
        tag_out = '0;
        drive(a, b, sew, sub, tag);
        bus.in_valid_i  = 1'b1;
        bus.out_ready_i = 1'b1;
        #1;
        n = 0;
        while (!bus.in_ready_o && n < 10) begin
            step();
            n++;
        end
        step();
        bus.in_valid_i = 1'b0;
        n = 0;
        while (!bus.out_valid_o && n < 10) begin
            step();
            n++;
        end
        if (bus.out_valid_o) begin
            ok      = 1'b1;
            sum     = bus.sum_o;
            cout    = bus.cout_o;
            tag_out = bus.tag_o;
            step();
        end
    endtask

    task automatic test_reset();
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        drive(64'h0, 64'h0, 2'b00, 1'b0, 4'h0);
        #12;
        total++; if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid_o); end
        total++; if (bus.sum_o !== 64'h0) begin bad++; $display("FAIL rst_sum got=%h exp=0", bus.sum_o); end
        total++; if (bus.cout_o !== 8'h0) begin bad++; $display("FAIL rst_cout got=%h exp=0", bus.cout_o); end
        total++; if (bus.tag_o !== 4'h0) begin bad++; $display("FAIL rst_tag got=%h exp=0", bus.tag_o); end
        total++; if (bus.in_ready_o !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready_o); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        total++; if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL idle_out_valid got=%b exp=0", bus.out_valid_o); end
    endtask

    task automatic test_byte_lanes();
        logic [63:0] s; logic [7:0] co; logic [3:0] tg; bit ok;
        run_single(64'hFFFF_FFFF_FFFF_FFFF, 64'h0101_0101_0101_0101, 2'b00, 1'b0, 4'h1, s, co, tg, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL byte_timeout got=%b exp=1", ok); end
        total++; if (s !== 64'h0) begin bad++; $display("FAIL byte_sum got=%h exp=0", s); end
        total++; if (co !== 8'hFF) begin bad++; $display("FAIL byte_cout got=%h exp=ff", co); end
        total++; if (tg !== 4'h1) begin bad++; $display("FAIL byte_tag got=%h exp=1", tg); end
    endtask

    task automatic test_full_width();
        logic [63:0] s; logic [7:0] co; logic [3:0] tg; bit ok;
        run_single(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 2'b11, 1'b0, 4'h2, s, co, tg, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL full_wrap_timeout got=%b exp=1", ok); end
        total++; if (s !== 64'h0) begin bad++; $display("FAIL full_wrap_sum got=%h exp=0", s); end
        total++; if (co !== 8'h80) begin bad++; $display("FAIL full_wrap_cout got=%h exp=80", co); end
        run_single(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 2'b11, 1'b0, 4'h3, s, co, tg, ok);
        total++; if (s !== 64'h8000_0000_0000_0000) begin bad++; $display("FAIL full_ovf_sum got=%h exp=8000000000000000", s); end
        total++; if (co !== 8'h00) begin bad++; $display("FAIL full_ovf_cout got=%h exp=00", co); end
        total++; if (tg !== 4'h3) begin bad++; $display("FAIL full_ovf_tag got=%h exp=3", tg); end
    endtask

    task automatic test_sub_lanes();
        logic [63:0] s; logic [7:0] co; logic [3:0] tg; bit ok;
        run_single(64'h0000_0005_0000_0007, 64'h0000_0007_0000_0005, 2'b10, 1'b1, 4'h4, s, co, tg, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL sub32_timeout got=%b exp=1", ok); end
        total++; if (s !== 64'hFFFF_FFFE_0000_0002) begin bad++; $display("FAIL sub32_sum got=%h exp=fffffffe00000002", s); end
        total++; if (co !== 8'h08) begin bad++; $display("FAIL sub32_cout got=%h exp=08", co); end
    endtask

    task automatic test_halfword_lanes();
        logic [63:0] s; logic [7:0] co; logic [3:0] tg; bit ok;
        run_single(64'hFFFF_0001_8000_00FF, 64'h0001_FFFF_8000_0001, 2'b01, 1'b0, 4'h5, s, co, tg, ok);
        total++; if (s !== 64'h0000_0000_0000_0100) begin bad++; $display("FAIL add16_sum got=%h exp=0000000000000100", s); end
        total++; if (co !== 8'hA8) begin bad++; $display("FAIL add16_cout got=%h exp=a8", co); end
    endtask

    task automatic test_sub_edges();
        logic [63:0] s; logic [7:0] co; logic [3:0] tg; bit ok;
        run_single(64'h0, 64'h1, 2'b11, 1'b1, 4'h6, s, co, tg, ok);
        total++; if (s !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL sub64_borrow_sum got=%h exp=ffffffffffffffff", s); end
        total++; if (co !== 8'h00) begin bad++; $display("FAIL sub64_borrow_cout got=%h exp=00", co); end
        run_single(64'h0, 64'h0, 2'b00, 1'b1, 4'h7, s, co, tg, ok);
        total++; if (s !== 64'h0) begin bad++; $display("FAIL sub8_zero_sum got=%h exp=0", s); end
        total++; if (co !== 8'hFF) begin bad++; $display("FAIL sub8_zero_cout got=%h exp=ff", co); end
    endtask

    task automatic test_back_to_back();
        bus.out_ready_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                drive(64'(c) << 8, 64'(c), 2'b11, 1'b0, 4'(c));
                bus.in_valid_i = 1'b1;
            end else begin
                bus.in_valid_i = 1'b0;
            end
            #1;
            if (c < 8) begin
                total++;
                if (bus.in_ready_o !== 1'b1) begin bad++; $display("FAIL b2b_in_ready c=%0d got=%b exp=1", c, bus.in_ready_o); end
            end
            step();
            if (c >= 1 && c <= 8) begin
                total++;
                if (bus.out_valid_o !== 1'b1 || bus.tag_o !== 4'(c - 1) || bus.sum_o !== 64'((c - 1) * 257)) begin
                    bad++;
                    $display("FAIL b2b_result c=%0d got v=%b tag=%h sum=%h exp v=1 tag=%h sum=%h",
                             c, bus.out_valid_o, bus.tag_o, bus.sum_o, 4'(c - 1), 64'((c - 1) * 257));
                end
            end else begin
                total++;
                if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL b2b_idle c=%0d got=%b exp=0", c, bus.out_valid_o); end
            end
        end
    endtask

    task automatic test_backpressure();
        int          next_tag = 0;
        int          acc      = 0;
        int          recv     = 0;
        bit          held     = 1'b0;
        bit          took;
        bit          cons;
        logic [63:0] held_sum = '0;
        logic [3:0]  held_tag = '0;
        bus.out_ready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drive(64'(next_tag), 64'h10, 2'b11, 1'b0, 4'(next_tag));
            bus.in_valid_i = 1'b1;
            #1;
            took = bus.in_ready_o;
            step();
            if (took) begin
                acc++;
                next_tag++;
            end
            if (bus.out_valid_o) begin
                if (held) begin
                    total++;
                    if (bus.sum_o !== held_sum || bus.tag_o !== held_tag) begin
                        bad++;
                        $display("FAIL bp_stable c=%0d got sum=%h tag=%h exp sum=%h tag=%h", c, bus.sum_o, bus.tag_o, held_sum, held_tag);
                    end
                end else begin
                    held     = 1'b1;
                    held_sum = bus.sum_o;
                    held_tag = bus.tag_o;
                end
            end
        end
        total++; if (acc !== 2) begin bad++; $display("FAIL bp_accepted got=%0d exp=2", acc); end
        total++; if (bus.in_ready_o !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b exp=0", bus.in_ready_o); end
        total++; if (held_tag !== 4'h0 || held_sum !== 64'h10) begin bad++; $display("FAIL bp_head got tag=%h sum=%h exp tag=0 sum=10", held_tag, held_sum); end

        bus.out_ready_i = 1'b1;
        for (int c = 0; c < 30 && recv < 6; c++) begin
            if (next_tag < 6) begin
                drive(64'(next_tag), 64'h10, 2'b11, 1'b0, 4'(next_tag));
                bus.in_valid_i = 1'b1;
            end else begin
                bus.in_valid_i = 1'b0;
            end
            #1;
            took = bus.in_valid_i & bus.in_ready_o;
            cons = bus.out_valid_o & bus.out_ready_i;
            if (cons) begin
                total++;
                if (bus.tag_o !== 4'(recv) || bus.sum_o !== 64'(recv + 16)) begin
                    bad++;
                    $display("FAIL bp_drain n=%0d got tag=%h sum=%h exp tag=%h sum=%h", recv, bus.tag_o, bus.sum_o, 4'(recv), 64'(recv + 16));
                end
                recv++;
            end
            step();
            if (took) next_tag++;
        end
        bus.in_valid_i = 1'b0;
        total++; if (recv !== 6) begin bad++; $display("FAIL bp_count got=%0d exp=6", recv); end
        total++; if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL bp_extra got=%b exp=0", bus.out_valid_o); end
    endtask

    task automatic test_reset_midstream();
        logic [63:0] s; logic [7:0] co; logic [3:0] tg; bit ok;
        bus.out_ready_i = 1'b1;
        drive(64'h1, 64'h2, 2'b11, 1'b0, 4'hA);
        bus.in_valid_i = 1'b1;
        step();
        drive(64'h3, 64'h4, 2'b11, 1'b0, 4'hB);
        step();
        bus.in_valid_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b exp=0", bus.out_valid_o); end
        total++; if (bus.sum_o !== 64'h0 || bus.cout_o !== 8'h0 || bus.tag_o !== 4'h0) begin
            bad++; $display("FAIL mid_rst_outputs got sum=%h cout=%h tag=%h exp all 0", bus.sum_o, bus.cout_o, bus.tag_o);
        end
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        total++; if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL mid_rst_residue got=%b exp=0", bus.out_valid_o); end
        run_single(64'h30, 64'h4, 2'b11, 1'b0, 4'hC, s, co, tg, ok);
        total++; if (ok !== 1'b1 || tg !== 4'hC || s !== 64'h34) begin
            bad++; $display("FAIL mid_rst_first got ok=%b tag=%h sum=%h exp ok=1 tag=c sum=34", ok, tg, s);
        end
    endtask

    initial begin
        test_reset();
        test_byte_lanes();
        test_full_width();
        test_sub_lanes();
        test_halfword_lanes();
        test_sub_edges();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
